// File: rtl/i2c_slave_mem.sv
`timescale 1ns/1ps
// i2c_slave_mem: oversampled I2C target fronting a 2**AW byte register file addressed by a write pointer.
// Latency: pins reach the FSM after 2+FILT PCLK; sda_oe changes SDA_HOLD PCLK after each detected SCL fall.
// Backpressure: none (no clock stretching); define I2C_SLV_GCALL_EN to also accept general-call writes.
module i2c_slave_mem #(
  parameter logic [6:0] I2C_ADR  = 7'h10,
  parameter int         AW       = 4,
  parameter int         FILT     = 3,
  parameter int         SDA_HOLD = 2
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          busy,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          rd_valid,
  output logic [AW-1:0] rd_addr
);

  localparam int DEPTH = 1 << AW;
  localparam int FW    = $clog2(FILT + 1);
  localparam int HW    = $clog2(SDA_HOLD + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK, IGNORE
  } state_t;

  state_t          state;
  logic [1:0]      scl_sync, sda_sync;
  logic            scl_f, sda_f, scl_q, sda_q;
  logic [FW-1:0]   scl_cnt, sda_cnt;
  logic [HW-1:0]   hold_cnt;
  logic [2:0]      bit_cnt;
  logic [6:0]      shreg;
  logic [6:0]      tx;
  logic            sda_want;
  logic            rd_mode;
  logic [AW-1:0]   ptr;
  logic [7:0]      mem [DEPTH];
  logic [7:0]      rx_byte;
  logic            addr_hit, ptr_ok;
  logic            scl_rise, scl_fall, start_evt, stop_evt;

  // Byte completed by the bit being sampled on this SCL rise
  assign rx_byte = {shreg, sda_f};
  assign ptr_ok  = ({1'b0, rx_byte} < 9'(DEPTH));

`ifdef I2C_SLV_GCALL_EN
  // General call (8'h00) joins the write path; 8'h01 is left unmatched
  assign addr_hit = (rx_byte[7:1] == I2C_ADR) || (rx_byte == 8'h00);
`else
  assign addr_hit = (rx_byte[7:1] == I2C_ADR);
`endif

  // Bus events from filtered levels; SCL must be stable high for START/STOP
  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_evt = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_evt  = scl_f & scl_q & ~sda_q & sda_f;

  // Synchronise both lines, then only accept a new level after FILT equal samples
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_cnt  <= '0;
      sda_cnt  <= '0;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      if (scl_sync[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == FW'(FILT - 1)) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 1'b1;
      end
      if (sda_sync[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == FW'(FILT - 1)) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 1'b1;
      end
    end
  end

  // Previous filtered levels for edge detection
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  // Protocol FSM: decides the next SDA drive on SCL rise, applies it SDA_HOLD after SCL fall
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= IDLE;
      sda_oe   <= 1'b0;
      sda_want <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rd_valid <= 1'b0;
      rd_addr  <= '0;
      hold_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= '0;
      rd_mode  <= 1'b0;
      ptr      <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      wr_valid <= 1'b0;
      rd_valid <= 1'b0;

      if (scl_fall) begin
        hold_cnt <= HW'(SDA_HOLD);
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
        if (hold_cnt == HW'(1)) sda_oe <= sda_want;
      end

      if (stop_evt) begin
        state    <= IDLE;
        sda_oe   <= 1'b0;
        sda_want <= 1'b0;
        hold_cnt <= '0;
        busy     <= 1'b0;
      end else if (start_evt) begin
        state    <= ADDR;
        bit_cnt  <= '0;
        sda_oe   <= 1'b0;
        sda_want <= 1'b0;
        hold_cnt <= '0;
        busy     <= 1'b1;
      end else if (scl_rise) begin
        case (state)
          ADDR: begin
            shreg   <= {shreg[5:0], sda_f};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              rd_mode  <= rx_byte[0];
              state    <= addr_hit ? ADDR_ACK : IGNORE;
              sda_want <= addr_hit;
            end
          end
          ADDR_ACK: begin
            bit_cnt <= '0;
            if (rd_mode) begin
              state    <= RDATA;
              tx       <= mem[ptr][6:0];
              sda_want <= ~mem[ptr][7];
              rd_valid <= 1'b1;
              rd_addr  <= ptr;
            end else begin
              state    <= PTR;
              sda_want <= 1'b0;
            end
          end
          PTR: begin
            shreg   <= {shreg[5:0], sda_f};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              if (ptr_ok) begin
                ptr      <= rx_byte[AW-1:0];
                state    <= PTR_ACK;
                sda_want <= 1'b1;
              end else begin
                state    <= IGNORE;
                sda_want <= 1'b0;
              end
            end
          end
          PTR_ACK, WDATA_ACK: begin
            bit_cnt  <= '0;
            state    <= WDATA;
            sda_want <= 1'b0;
          end
          WDATA: begin
            shreg   <= {shreg[5:0], sda_f};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              mem[ptr] <= rx_byte;
              wr_valid <= 1'b1;
              wr_addr  <= ptr;
              wr_data  <= rx_byte;
              ptr      <= ptr + 1'b1;
              state    <= WDATA_ACK;
              sda_want <= 1'b1;
            end
          end
          RDATA: begin
            tx      <= {tx[5:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              state    <= RDATA_MACK;
              sda_want <= 1'b0;
              ptr      <= ptr + 1'b1;
            end else begin
              sda_want <= ~tx[6];
            end
          end
          RDATA_MACK: begin
            bit_cnt <= '0;
            if (!sda_f) begin
              state    <= RDATA;
              tx       <= mem[ptr][6:0];
              sda_want <= ~mem[ptr][7];
              rd_valid <= 1'b1;
              rd_addr  <= ptr;
            end else begin
              state    <= IGNORE;
              sda_want <= 1'b0;
            end
          end
          default: sda_want <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_mem.sv
`timescale 1ns/1ps
// tb_i2c_slave_mem: drives an open-drain I2C master against i2c_slave_mem and scores it against a byte-array model.
// Latency: bit-level master with 4*Q PCLK per SCL period.
// Backpressure: none; every wait is a fixed cycle count plus a global watchdog.
module tb_i2c_slave_mem;

  localparam int Q     = 8;
  localparam int DEPTH = 16;
`ifdef I2C_SLV_GCALL_EN
  localparam bit GCALL = 1'b1;
`else
  localparam bit GCALL = 1'b0;
`endif

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe, busy, wr_valid, rd_valid;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_mem dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .scl_i(scl_m), .sda_i(sda_bus),
    .sda_oe(sda_oe), .busy(busy),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_addr(rd_addr)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_bad = 0;
  int oe_viol = 0;

  // reference model: memory image, pointer, expected/observed strobe streams
  logic [7:0] ref_mem [DEPTH];
  int         ref_ptr;
  int         exp_wr[$], obs_wr[$], exp_rd[$], obs_rd[$];
  logic [7:0] wdata[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // strobe capture and a watch for sda_oe moving while SCL is high
  logic prev_oe = 1'b0;
  logic prev_rst = 1'b0;
  always @(negedge PCLK) begin
    if (PRESETn) begin
      if (wr_valid) obs_wr.push_back(int'({wr_addr, wr_data}));
      if (rd_valid) obs_rd.push_back(int'(rd_addr));
      if (prev_rst && scl_m && (sda_oe !== prev_oe)) oe_viol++;
    end
    prev_oe  = sda_oe;
    prev_rst = PRESETn;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    ref_ptr = 0;
  endtask

  task automatic wq();
    repeat (Q) @(negedge PCLK);
  endtask

  task automatic i2c_start();
    if (!scl_m) begin
      wq(); sda_m = 1'b1; wq(); scl_m = 1'b1; wq();
    end
    sda_m = 1'b0; wq(); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wq(); sda_m = 1'b0; wq(); scl_m = 1'b1; wq(); sda_m = 1'b1; wq();
  endtask

  task automatic i2c_bit(input logic b, output logic r);
    wq(); sda_m = b; wq(); scl_m = 1'b1; wq(); r = sda_bus; wq(); scl_m = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
    i2c_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, r);
      d[i] = r;
    end
    i2c_bit(nack, r);
  endtask

  // START, address byte, pointer byte, then every byte in wdata
  task automatic m_write(input logic [7:0] ab, input logic [7:0] pb, input string tag);
    logic ack, hit, ok;
    i2c_start();
    chk({tag, "_busy_start"}, busy, 1);
    hit = (ab == 8'h20) || (GCALL && ab == 8'h00);
    wr_byte(ab, ack);
    chk({tag, "_addr_ack"}, ack, hit);
    ok = hit && (pb < DEPTH);
    wr_byte(pb, ack);
    chk({tag, "_ptr_ack"}, ack, ok);
    if (ok) ref_ptr = int'(pb);
    foreach (wdata[i]) begin
      wr_byte(wdata[i], ack);
      chk({tag, "_data_ack"}, ack, ok);
      if (ok) begin
        ref_mem[ref_ptr] = wdata[i];
        exp_wr.push_back(ref_ptr * 256 + int'(wdata[i]));
        ref_ptr = (ref_ptr + 1) % DEPTH;
      end
    end
  endtask

  // START, address byte, n bytes read with ACK except a final NACK
  task automatic m_read(input logic [7:0] ab, input int n, input string tag);
    logic ack, hit;
    logic [7:0] d, e;
    i2c_start();
    hit = (ab == 8'h21);
    wr_byte(ab, ack);
    chk({tag, "_raddr_ack"}, ack, hit);
    for (int i = 0; i < n; i++) begin
      rd_byte(i == n - 1, d);
      e = hit ? ref_mem[ref_ptr] : 8'hFF;
      chk({tag, "_rdata"}, d, e);
      if (hit) begin
        exp_rd.push_back(ref_ptr);
        ref_ptr = (ref_ptr + 1) % DEPTH;
      end
    end
    repeat (2 * Q) @(negedge PCLK);
    chk({tag, "_released"}, sda_oe, 0);
  endtask

  // STOP, then score the strobes seen during the transaction
  task automatic end_txn(input string tag);
    i2c_stop();
    repeat (2 * Q) @(negedge PCLK);
    chk({tag, "_busy_stop"}, busy, 0);
    chk({tag, "_wr_cnt"}, obs_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size(); i++)
      chk({tag, "_wr_ev"}, (i < obs_wr.size()) ? obs_wr[i] : -1, exp_wr[i]);
    chk({tag, "_rd_cnt"}, obs_rd.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size(); i++)
      chk({tag, "_rd_ev"}, (i < obs_rd.size()) ? obs_rd[i] : -1, exp_rd[i]);
    exp_wr.delete(); obs_wr.delete(); exp_rd.delete(); obs_rd.delete();
  endtask

  initial begin
    logic [7:0] ab, rab;
    logic ack;
    int kind, n;

    model_reset();
    repeat (4) @(negedge PCLK);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_addr", rd_addr, 0);
    PRESETn = 1'b1;
    repeat (10) @(negedge PCLK);

    // pointer write, repeated START, two reads from fresh memory
    wdata = {};
    m_write(8'h20, 8'h02, "rs");
    m_read(8'h21, 2, "rs");
    end_txn("rs");

    // two data writes, then read back at the post-increment pointer
    wdata = {8'hA5, 8'h5A};
    m_write(8'h20, 8'h03, "wr");
    end_txn("wr");
    m_read(8'h21, 1, "ptr5");
    end_txn("ptr5");

    // pointer wrap on write and on read
    wdata = {8'h11, 8'h22};
    m_write(8'h20, 8'h0F, "wrapw");
    end_txn("wrapw");
    wdata = {};
    m_write(8'h20, 8'h0F, "wrapr");
    m_read(8'h21, 2, "wrapr");
    end_txn("wrapr");

    // out-of-range pointer is refused and the pointer is kept
    wdata = {8'h77, 8'h88};
    m_write(8'h20, 8'h10, "badptr");
    end_txn("badptr");
    m_read(8'h21, 1, "badptr_rd");
    end_txn("badptr_rd");

    // foreign address and general-call address
    wdata = {8'h99};
    m_write(8'h42, 8'h01, "foreign");
    end_txn("foreign");
    wdata = {8'hC3};
    m_write(8'h00, 8'h06, "gcall");
    end_txn("gcall");
    m_read(8'h21, 1, "gcall_rd");
    end_txn("gcall_rd");

    // randomized mix of writes, write+read and reads
    for (int t = 0; t < 12; t++) begin
      kind = $urandom_range(0, 2);
      case ($urandom_range(0, 9))
        7:       ab = 8'h42;
        8:       ab = 8'h00;
        9:       ab = 8'h55;
        default: ab = 8'h20;
      endcase
      rab = ($urandom_range(0, 4) == 0) ? 8'h43 : 8'h21;
      n = $urandom_range(0, 3);
      wdata = {};
      for (int i = 0; i < n; i++) wdata.push_back(8'($urandom_range(0, 255)));
      if (kind != 2) m_write(ab, 8'($urandom_range(0, 19)), "rnd");
      if (kind != 0) m_read(rab, $urandom_range(1, 3), "rnd");
      end_txn("rnd");
    end

    // reset while the target pulls SDA low on a read data bit
    wdata = {8'h00};
    m_write(8'h20, 8'h00, "prerst");
    end_txn("prerst");
    wdata = {};
    m_write(8'h20, 8'h00, "midrst");
    i2c_start();
    wr_byte(8'h21, ack);
    chk("midrst_addr_ack", ack, 1);
    for (int k = 0; k < 3 * Q && !sda_oe; k++) @(negedge PCLK);
    chk("midrst_oe_before", sda_oe, 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("midrst_oe_async", sda_oe, 0);
    chk("midrst_busy_async", busy, 0);
    model_reset();
    repeat (4) @(negedge PCLK);
    PRESETn = 1'b1;
    exp_wr.delete(); obs_wr.delete(); exp_rd.delete(); obs_rd.delete();
    repeat (2 * Q) @(negedge PCLK);
    chk("midrst_oe_after", sda_oe, 0);
    i2c_stop();
    wdata = {};
    m_write(8'h20, 8'h00, "postrst");
    m_read(8'h21, 1, "postrst");
    end_txn("postrst");

    chk("oe_change_scl_high", oe_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
